fetch_queue_unit: RTL

//  Parametrised instruction-fetch front end for the 5-stage RV32 pipeline.
//  - Owns the PC and issues requests to a fixed 1-cycle-latency instruction memory.
//  - Buffers fetched {pc,instr} pairs in a DEPTH-entry prefetch queue, so decode stalls no longer freeze fetch.
//  - Takes branch/jump redirects from EX and a halt request.
//  - Sits between instruction memory and the IF/ID boundary, and replaces the bare PC register/adder/mux.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_queue_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch front end.
package fetch_pkg;
  localparam int DEF_PC_W  = 9;
  localparam int DEF_INS_W = 32;
  localparam int DEF_DEPTH = 4;
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_PC_W-1:0]  pc;
    logic [DEF_INS_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush, occupancy count and combinational head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_pop, do_push;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  // The issue credit upstream must make this unreachable.
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(do_push && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the PC, issues 1-cycle imem requests and queues {pc,instr} for decode.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INS_W    = DEF_INS_W,
  parameter int              DEPTH    = DEF_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_STEP  = PC_W'(4)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  input  logic                   halt,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INS_W-1:0]       imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [INS_W-1:0]       out_instr,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   halted
);
  localparam int CW = $clog2(DEPTH);

  logic [PC_W-1:0] fetch_pc, imem_addr_q;
  logic            inflight, kill, halted_q;
  logic [CW+1:0]   occ;
  logic            credit, push, pop;
  fetch_entry_t    push_data, head;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // An outstanding request already owns a slot, so count it against the queue.
  assign occ      = (CW+2)'(q_count) + (CW+2)'(inflight);
  assign credit   = occ < (CW+2)'(DEPTH);
  assign imem_req = ~reset & ~halt & ~redirect_valid & credit;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      imem_addr_q <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      if (redirect_valid)  fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
      else if (imem_req)   fetch_pc <= fetch_pc + PC_STEP;
      if (imem_req) imem_addr_q <= fetch_pc;
      inflight <= imem_req;
      kill     <= redirect_valid;
      halted_q <= halt & ~inflight;
    end
  end

  assign push            = inflight & ~kill & ~redirect_valid;
  assign pop             = out_valid & out_ready;
  assign push_data.pc    = imem_addr_q;
  assign push_data.instr = imem_rdata;

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (q_count)
  );

  assign out_valid = (q_count != '0) & ~redirect_valid;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign halted    = halted_q;
endmodule
